// File: rtl/fir_coef_ctrl_if.sv
// Handshake and filter-control signals between the coefficient/sample source
// and the FIR controller.
interface fir_coef_ctrl_if #(
    parameter int ORDER = 5
);
    logic                        load_start;
    logic                        coef_valid;
    logic signed [17:0]          coef_data;
    logic                        coef_ready;
    logic                        s_valid;
    logic signed [17:0]          s_data;
    logic                        s_ready;
    logic                        fir_ena;
    logic signed [17:0]          fir_x;
    logic [(ORDER+1)*18-1:0]     coef_bus;
    logic                        out_valid;
    logic                        busy;
    logic                        load_done;

    modport master (
        output load_start, coef_valid, coef_data, s_valid, s_data,
        input  coef_ready, s_ready, fir_ena, fir_x, coef_bus, out_valid, busy, load_done
    );

    modport slave (
        input  load_start, coef_valid, coef_data, s_valid, s_data,
        output coef_ready, s_ready, fir_ena, fir_x, coef_bus, out_valid, busy, load_done
    );
endinterface

// File: rtl/fir_coef_ctrl.sv
// Coefficient bank owner and stream sequencer for a transposed-form FIR:
// load bank, flush the pipeline with zeros, then stream samples and flag valid outputs.
module fir_coef_ctrl #(
    parameter int ORDER = 5,
    parameter int LAT   = ORDER + 2
) (
    input  logic            clk,
    input  logic            rst,
    fir_coef_ctrl_if.slave  bus
);
    localparam int NC = ORDER + 1;
    localparam int CW = 18;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;
    localparam int FW = $clog2(LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [IW-1:0]          idx_reg;
    logic [FW-1:0]          flush_cnt_reg;
    // Only the taps up to LAT-2 are ever observed, so the shift register stops there.
    logic [LAT-2:0]         vld_sr_reg;
    logic                   out_valid_reg;
    logic                   load_done_reg;
    logic signed [CW-1:0]   shadow_reg [NC];
    logic signed [CW-1:0]   coef_reg   [NC];

    logic coef_ready_c;
    logic s_ready_c;
    logic accept_c;
    logic fir_ena_c;
    logic take_word;
    logic last_word;

    assign coef_ready_c = (state_reg == WRITE);
    assign take_word    = coef_ready_c & bus.coef_valid;
    assign last_word    = take_word && (idx_reg == IW'(ORDER));
    assign s_ready_c    = (state_reg == RUN) && !bus.load_start;
    assign accept_c     = s_ready_c & bus.s_valid;
    assign fir_ena_c    = (state_reg == FLUSH) || accept_c;

    assign bus.coef_ready = coef_ready_c;
    assign bus.s_ready    = s_ready_c;
    assign bus.fir_ena    = fir_ena_c;
    assign bus.fir_x      = accept_c ? bus.s_data : '0;
    assign bus.out_valid  = out_valid_reg;
    assign bus.load_done  = load_done_reg;
    assign bus.busy       = (state_reg != RUN);

    // The committed copy takes the final word straight from the port, since the
    // shadow entry for it is being written on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_bank
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    shadow_reg[gi] <= '0;
                    coef_reg[gi]   <= '0;
                end else begin
                    if (take_word && (idx_reg == IW'(gi)))
                        shadow_reg[gi] <= bus.coef_data;
                    if (last_word)
                        coef_reg[gi] <= (gi == ORDER) ? bus.coef_data : shadow_reg[gi];
                end
            end
            assign bus.coef_bus[gi*CW +: CW] = coef_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            flush_cnt_reg <= '0;
            vld_sr_reg    <= '0;
            out_valid_reg <= 1'b0;
            load_done_reg <= 1'b0;
        end else begin
            load_done_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.load_start) begin
                        state_reg <= WRITE;
                        idx_reg   <= '0;
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        idx_reg       <= '0;
                        flush_cnt_reg <= FW'(LAT - 1);
                        vld_sr_reg    <= '0;
                        state_reg     <= FLUSH;
                    end else if (take_word) begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg == '0) begin
                        state_reg     <= RUN;
                        load_done_reg <= 1'b1;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg - 1'b1;
                    end
                end
                RUN: begin
                    if (bus.load_start) begin
                        state_reg  <= WRITE;
                        idx_reg    <= '0;
                        vld_sr_reg <= '0;
                    end else if (accept_c) begin
                        // Valid pipeline advances only with the filter enable.
                        vld_sr_reg    <= (LAT-1)'({vld_sr_reg, 1'b1});
                        out_valid_reg <= vld_sr_reg[LAT-2];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: table-driven load sequence plus hand-written
// streaming, reload and reset sequences.
module tb_fir_coef_ctrl;
    localparam int ORDER = 5;
    localparam int LAT   = ORDER + 2;
    localparam int NC    = ORDER + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_coef_ctrl_if #(.ORDER(ORDER)) bus ();

    fir_coef_ctrl #(.ORDER(ORDER), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic               ls;
        logic               cv;
        logic signed [17:0] cd;
        logic               sv;
        logic signed [17:0] sd;
        logic               e_cr;
        logic               e_sr;
        logic               e_ena;
        logic signed [17:0] e_x;
        logic               e_busy;
        logic               e_ld;
        logic signed [17:0] e_b0;
        logic signed [17:0] e_b3;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ls, input logic cv, input int cd,
                                input logic sv, input int sd,
                                input logic cr, input logic sr, input logic ena,
                                input int x, input logic bsy, input logic ld,
                                input int b0, input int b3);
        vec_t v;
        v.ls = ls; v.cv = cv; v.cd = 18'(cd); v.sv = sv; v.sd = 18'(sd);
        v.e_cr = cr; v.e_sr = sr; v.e_ena = ena; v.e_x = 18'(x);
        v.e_busy = bsy; v.e_ld = ld; v.e_b0 = 18'(b0); v.e_b3 = 18'(b3);
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [17:0] bank(input int j);
        logic [17:0] w;
        w = bus.coef_bus[j*18 +: 18];
        return $signed(w);
    endfunction

    logic signed [17:0] xq[$];
    int  imp_exp[6] = '{200, 152, 48, -30, -37, 0};
    int  tog_w[6]   = '{1, -2, 3, -4, 5, -6};
    int  gap_pat[12] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int  wr_seq[6]  = '{200, 152, 48, -30, -37, 0};

    initial begin
        bus.load_start = 1'b0;
        bus.coef_valid = 1'b0;
        bus.coef_data  = '0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;

        // Reset state
        #1 rst = 1'b0;
        #2;
        chk("rst_busy", bus.busy, 1);
        chk("rst_coef_ready", bus.coef_ready, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_fir_ena", bus.fir_ena, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_load_done", bus.load_done, 0);
        chk("rst_coef_bus_b0", bank(0), 0);
        cycle_start();
        rst = 1'b1;

        // Back-to-back load table: ls cv cd sv sd | cr sr ena x busy ld b0 b3
        tbl.push_back(mk(0, 1, 99, 1, 7,   0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  0, 0,   0, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(k == 1, 1, wr_seq[k], k == 1, 9,
                             1, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < LAT; k++)
            tbl.push_back(mk(0, 1, 77, 1, 55, 0, 0, 1, 0, 1, 0, 200, -30));
        tbl.push_back(mk(0, 0, 0, 0, 0,    0, 1, 0, 0, 0, 1, 200, -30));
        tbl.push_back(mk(0, 0, 0, 0, 0,    0, 1, 0, 0, 0, 0, 200, -30));

        for (int r = 0; r < tbl.size(); r++) begin
            cycle_start();
            bus.load_start = tbl[r].ls;
            bus.coef_valid = tbl[r].cv;
            bus.coef_data  = tbl[r].cd;
            bus.s_valid    = tbl[r].sv;
            bus.s_data     = tbl[r].sd;
            #2;
            chk($sformatf("row%0d_coef_ready", r), bus.coef_ready, tbl[r].e_cr);
            chk($sformatf("row%0d_s_ready", r), bus.s_ready, tbl[r].e_sr);
            chk($sformatf("row%0d_fir_ena", r), bus.fir_ena, tbl[r].e_ena);
            chk($sformatf("row%0d_fir_x", r), bus.fir_x, tbl[r].e_x);
            chk($sformatf("row%0d_busy", r), bus.busy, tbl[r].e_busy);
            chk($sformatf("row%0d_load_done", r), bus.load_done, tbl[r].e_ld);
            chk($sformatf("row%0d_out_valid", r), bus.out_valid, 0);
            chk($sformatf("row%0d_bus_b0", r), bank(0), tbl[r].e_b0);
            chk($sformatf("row%0d_bus_b3", r), bank(3), tbl[r].e_b3);
        end

        // Impulse stream with a behavioural transposed FIR on the outputs
        begin
            int n_en = 0;
            int nvalid = 0;
            for (int i = 0; i < 16; i++) begin
                cycle_start();
                bus.s_valid = 1'b1;
                bus.s_data  = (i == 0) ? 18'sd1 : 18'sd0;
                #2;
                if (bus.out_valid === 1'b1) begin
                    int r;
                    logic signed [47:0] acc;
                    r = n_en - LAT;
                    acc = '0;
                    for (int j = 0; j < NC; j++)
                        if (r - j >= 0) acc += bank(j) * xq[r - j];
                    if (nvalid == 0) chk("imp_latency", i, LAT);
                    if (nvalid < 6) chk($sformatf("imp_dout%0d", nvalid), 32'(acc), imp_exp[nvalid]);
                    nvalid++;
                end
                if (bus.fir_ena === 1'b1) begin
                    xq.push_back(bus.fir_x);
                    n_en++;
                end
            end
            chk("imp_nvalid", nvalid, 16 - LAT);
        end

        // load_start together with s_valid in RUN: load wins
        cycle_start();
        bus.load_start = 1'b1;
        bus.s_valid    = 1'b1;
        bus.s_data     = 18'sd123;
        #2;
        chk("ls_s_ready", bus.s_ready, 0);
        chk("ls_fir_ena", bus.fir_ena, 0);
        chk("ls_fir_x", bus.fir_x, 0);
        chk("ls_out_valid_before", bus.out_valid, 1);
        cycle_start();
        bus.load_start = 1'b0;
        bus.s_valid    = 1'b0;
        #2;
        chk("ls_out_valid_after", bus.out_valid, 0);
        chk("ls_coef_ready", bus.coef_ready, 1);
        chk("ls_busy", bus.busy, 1);

        // Reload with coef_valid toggling: 6 words over 11 cycles
        for (int k = 0; k < 11; k++) begin
            cycle_start();
            bus.coef_valid = (k % 2 == 0);
            bus.coef_data  = (k % 2 == 0) ? 18'(tog_w[k/2]) : 18'sd999;
            #2;
            chk($sformatf("tog%0d_coef_ready", k), bus.coef_ready, 1);
            chk($sformatf("tog%0d_bus_b0", k), bank(0), 200);
        end
        cycle_start();
        bus.coef_valid = 1'b0;
        #2;
        chk("tog_flush_ena", bus.fir_ena, 1);
        chk("tog_flush_coef_ready", bus.coef_ready, 0);
        for (int j = 0; j < NC; j++)
            chk($sformatf("tog_bank%0d", j), bank(j), tog_w[j]);
        begin
            int flush_n = 1;
            logic got_ld = 1'b0;
            for (int t = 0; t < 20 && !got_ld; t++) begin
                cycle_start();
                #2;
                if (bus.load_done === 1'b1) got_ld = 1'b1;
                else if (bus.fir_ena === 1'b1) flush_n++;
            end
            chk("tog_load_done_seen", got_ld, 1);
            chk("tog_flush_cycles", flush_n, LAT);
        end

        // Gapped s_valid after a fresh load
        begin
            int acc_n = 0;
            int prev_idx = 0;
            logic prev_ena = 1'b0;
            for (int i = 0; i < 12; i++) begin
                cycle_start();
                bus.s_valid = gap_pat[i][0];
                bus.s_data  = 18'(100 + i);
                #2;
                chk($sformatf("gap%0d_out_valid", i), bus.out_valid,
                    (prev_ena && prev_idx >= LAT - 1) ? 1 : 0);
                chk($sformatf("gap%0d_fir_ena", i), bus.fir_ena, gap_pat[i]);
                chk($sformatf("gap%0d_fir_x", i), bus.fir_x, gap_pat[i] ? 100 + i : 0);
                prev_ena = gap_pat[i][0];
                prev_idx = acc_n;
                if (gap_pat[i] != 0) acc_n++;
            end
        end

        // Reset mid-WRITE after 3 words
        cycle_start();
        bus.s_valid    = 1'b0;
        bus.load_start = 1'b1;
        cycle_start();
        bus.load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle_start();
            bus.coef_valid = 1'b1;
            bus.coef_data  = 18'(wr_seq[k]);
        end
        cycle_start();
        bus.coef_valid = 1'b0;
        chk("mid_bus_b0_before", bank(0), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_bus_b0", bank(0), 0);
        chk("mid_rst_bus_b5", bank(5), 0);
        chk("mid_rst_coef_ready", bus.coef_ready, 0);
        chk("mid_rst_s_ready", bus.s_ready, 0);
        chk("mid_rst_busy", bus.busy, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        #10;
        rst = 1'b1;
        cycle_start();
        #2;
        chk("mid_idle_s_ready", bus.s_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
